// File: rtl/clock_pkg.sv
// Shared constants and helpers for the multi-mode clock time-keeping path.
package clock_pkg;

  localparam int unsigned TIME_W   = 8;
  localparam int unsigned HOUR_MOD = 24;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned RST_HOUR = 8;

  typedef logic [TIME_W-1:0] field_t;

  // True when v is a legal count for a field of the given modulus.
  function automatic logic in_range(field_t v, int unsigned modulus);
    return v <= field_t'(modulus - 1);
  endfunction

endpackage

// File: rtl/time_keep_if.sv
// Set-mode / display bus between the time keeper and its neighbours.
interface time_keep_if;

  logic              tick;
  logic              modify;
  logic              leave;
  clock_pkg::field_t set_hour;
  clock_pkg::field_t set_minute;
  clock_pkg::field_t set_second;
  clock_pkg::field_t cur_hour;
  clock_pkg::field_t cur_minute;
  clock_pkg::field_t cur_second;
  logic              min_pulse;
  logic              hour_pulse;
  logic              day_pulse;
  logic              load_done;
  logic              load_err;

  modport master (
    output tick, modify, leave, set_hour, set_minute, set_second,
    input  cur_hour, cur_minute, cur_second,
    input  min_pulse, hour_pulse, day_pulse, load_done, load_err
  );

  modport slave (
    input  tick, modify, leave, set_hour, set_minute, set_second,
    output cur_hour, cur_minute, cur_second,
    output min_pulse, hour_pulse, day_pulse, load_done, load_err
  );

endinterface

// File: rtl/time_keep_mod_cnt.sv
// Modulo-MOD field counter with clamped parallel load; wrap is the combinational
// carry-out so the next field can advance in the same cycle.
module mod_cnt
  import clock_pkg::*;
#(
  parameter int unsigned MOD     = 60,
  parameter int unsigned RST_VAL = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  input  logic   load,
  input  field_t load_val,
  output field_t q,
  output logic   wrap
);

  localparam field_t MAX_Q = field_t'(MOD - 1);
  localparam field_t RST_Q = field_t'(RST_VAL);

  assign wrap = inc && (q == MAX_Q);

  // Load wins over increment; an out-of-range load value lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_Q;
    end else if (load) begin
      q <= in_range(load_val, MOD) ? load_val : '0;
    end else if (inc) begin
      q <= wrap ? '0 : q + field_t'(1);
    end
  end

endmodule

// File: rtl/time_keep.sv
// Running time of day: hh:mm:ss counter chain with set-mode commit and carry pulses.
module time_keep
  import clock_pkg::*;
#(
  parameter int unsigned HOUR     = HOUR_MOD,
  parameter int unsigned MINUTE   = MIN_MOD,
  parameter int unsigned SECOND   = SEC_MOD,
  parameter int unsigned RST_HOUR = clock_pkg::RST_HOUR
) (
  input  logic        clk,
  input  logic        rst_n,
  time_keep_if.slave  bus
);

  logic   commit_c;
  logic   count_c;
  logic   sec_wrap;
  logic   min_wrap;
  logic   hour_wrap;
  logic   clamp_c;
  field_t sec_q;
  field_t min_q;
  field_t hour_q;
  logic   min_pulse;
  logic   hour_pulse;
  logic   day_pulse;
  logic   load_done;
  logic   load_err;

  // A commit overrides a coincident tick, so that tick is simply dropped.
  assign commit_c = bus.leave & bus.modify;
  assign count_c  = bus.tick & ~commit_c;

  assign clamp_c = ~in_range(bus.set_hour, HOUR)
                 | ~in_range(bus.set_minute, MINUTE)
                 | ~in_range(bus.set_second, SECOND);

  mod_cnt #(.MOD(SECOND), .RST_VAL(0)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (count_c),
    .load     (commit_c),
    .load_val (bus.set_second),
    .q        (sec_q),
    .wrap     (sec_wrap)
  );

  mod_cnt #(.MOD(MINUTE), .RST_VAL(0)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sec_wrap),
    .load     (commit_c),
    .load_val (bus.set_minute),
    .q        (min_q),
    .wrap     (min_wrap)
  );

  mod_cnt #(.MOD(HOUR), .RST_VAL(RST_HOUR)) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (min_wrap),
    .load     (commit_c),
    .load_val (bus.set_hour),
    .q        (hour_q),
    .wrap     (hour_wrap)
  );

  // Pulses line up with the counter update they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      min_pulse  <= sec_wrap;
      hour_pulse <= min_wrap;
      day_pulse  <= hour_wrap;
      load_done  <= commit_c;
      load_err   <= commit_c & clamp_c;
    end
  end

  assign bus.cur_hour   = hour_q;
  assign bus.cur_minute = min_q;
  assign bus.cur_second = sec_q;
  assign bus.min_pulse  = min_pulse;
  assign bus.hour_pulse = hour_pulse;
  assign bus.day_pulse  = day_pulse;
  assign bus.load_done  = load_done;
  assign bus.load_err   = load_err;

endmodule

// File: tb/tb_time_keep.sv
// Scoreboard bench for time_keep: directed stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_time_keep;
  import clock_pkg::*;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_HOUR = 5'b01000;
  localparam logic [4:0] F_DAY  = 5'b00100;
  localparam logic [4:0] F_LD   = 5'b00010;
  localparam logic [4:0] F_LE   = 5'b00001;

  typedef struct {
    int         cyc;
    string      name;
    field_t     h;
    field_t     m;
    field_t     s;
    logic [4:0] flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  time_keep_if bus();

  time_keep dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic t, input logic lv, input logic md,
                       input field_t h, input field_t m, input field_t s);
    @(posedge clk);
    #1;
    bus.tick       = t;
    bus.leave      = lv;
    bus.modify     = md;
    bus.set_hour   = h;
    bus.set_minute = m;
    bus.set_second = s;
  endtask

  task automatic exp_at(input int c, input string nm, input field_t h, input field_t m,
                        input field_t s, input logic [4:0] fl);
    exp_t e;
    e.cyc = c; e.name = nm; e.h = h; e.m = m; e.s = s; e.flags = fl;
    sbq.push_back(e);
  endtask

  task automatic exp_next(input string nm, input field_t h, input field_t m,
                          input field_t s, input logic [4:0] fl);
    exp_at(cyc + 1, nm, h, m, s, fl);
  endtask

  // Monitor: compare every expectation due this cycle; a stale one is a miss.
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e   = sbq.pop_front();
        act = {bus.min_pulse, bus.hour_pulse, bus.day_pulse, bus.load_done, bus.load_err};
        checks++;
        if (e.cyc != cyc || bus.cur_hour != e.h || bus.cur_minute != e.m ||
            bus.cur_second != e.s || act != e.flags) begin
          errors++;
          $display("FAIL %s @cyc %0d (due %0d): got %0d:%0d:%0d flags=%b, expected %0d:%0d:%0d flags=%b",
                   e.name, cyc, e.cyc, bus.cur_hour, bus.cur_minute, bus.cur_second, act,
                   e.h, e.m, e.s, e.flags);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.tick       = 1'b0;
    bus.leave      = 1'b0;
    bus.modify     = 1'b0;
    bus.set_hour   = '0;
    bus.set_minute = '0;
    bus.set_second = '0;

    repeat (2) @(posedge clk);
    #1;
    exp_at(cyc, "reset", 8'd8, 8'd0, 8'd0, F_NONE);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    drive(1, 0, 0, 0, 0, 0);     exp_next("tick1", 8, 0, 1, F_NONE);
    drive(1, 0, 0, 0, 0, 0);     exp_next("tick2", 8, 0, 2, F_NONE);
    drive(1, 0, 0, 0, 0, 0);     exp_next("tick3", 8, 0, 3, F_NONE);

    drive(0, 1, 1, 23, 59, 59);  exp_next("load_235959", 23, 59, 59, F_LD);
    drive(1, 0, 0, 0, 0, 0);     exp_next("day_roll", 0, 0, 0, F_MIN | F_HOUR | F_DAY);
    drive(0, 0, 0, 0, 0, 0);     exp_next("pulse_clear", 0, 0, 0, F_NONE);

    drive(0, 1, 1, 10, 14, 59);  exp_next("load_101459", 10, 14, 59, F_LD);
    drive(1, 0, 0, 0, 0, 0);     exp_next("min_carry", 10, 15, 0, F_MIN);

    drive(0, 1, 1, 12, 0, 0);    exp_next("load_120000", 12, 0, 0, F_LD);
    drive(1, 1, 1, 5, 6, 7);     exp_next("commit_vs_tick", 5, 6, 7, F_LD);
    drive(0, 1, 0, 1, 2, 3);     exp_next("noop_leave", 5, 6, 7, F_NONE);
    drive(1, 1, 0, 1, 2, 3);     exp_next("noop_leave_tick", 5, 6, 8, F_NONE);

    drive(0, 1, 1, 25, 30, 61);  exp_next("clamp_h_s", 0, 30, 0, F_LD | F_LE);
    drive(0, 1, 1, 23, 60, 5);   exp_next("clamp_min60", 23, 0, 5, F_LD | F_LE);
    drive(0, 1, 1, 24, 59, 59);  exp_next("clamp_hour24", 0, 59, 59, F_LD | F_LE);
    drive(1, 0, 0, 0, 0, 0);     exp_next("hour_carry", 1, 0, 0, F_MIN | F_HOUR);
    drive(0, 1, 1, 23, 59, 58);  exp_next("load_max_ok", 23, 59, 58, F_LD);
    drive(1, 0, 0, 0, 0, 0);     exp_next("tick_to_max", 23, 59, 59, F_NONE);

    drive(0, 1, 1, 15, 45, 29);  exp_next("load_154529", 15, 45, 29, F_LD);
    drive(1, 0, 0, 0, 0, 0);     exp_next("tick_154530", 15, 45, 30, F_NONE);
    drive(0, 0, 0, 0, 0, 0);

    // Reset lands mid-cycle; the negedge sample precedes any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_at(cyc, "async_rst", 8, 0, 0, F_NONE);
    drive(1, 1, 1, 3, 3, 3);     exp_next("rst_hold", 8, 0, 0, F_NONE);
    drive(1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;                exp_next("after_rst_tick", 8, 0, 1, F_NONE);
    drive(0, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending: got %0d unchecked expectations, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_keep.md
Name: time_keep

Overview:
- Owns the running time of day for the multi-mode clock.
- Advances hh:mm:ss once per 1 Hz tick and drives cur_hour/cur_minute/cur_second to the set-mode block and to the display path.
- Accepts the set-mode block's edited time: the new time is committed when the user leaves set mode and a modification was made.
- Emits single-cycle rollover pulses for alarm/chime logic.

Parameters:
- HOUR, 24, hour modulus; hour counts 0..HOUR-1.
- MINUTE, 60, minute modulus; minute counts 0..MINUTE-1.
- SECOND, 60, second modulus; second counts 0..SECOND-1.
- RST_HOUR, 8, hour value after reset.

Ports:
- clk  in  1  fast system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  1 Hz enable; one clk wide; produced by the divider in the clk domain.
- modify  in  1  level from set-mode block; high = user edited the time.
- leave  in  1  one-cycle pulse; user exits set mode.
- set_hour  in  8  edited hour.
- set_minute  in  8  edited minute.
- set_second  in  8  edited second.
- cur_hour  out  8  running hour, binary.
- cur_minute  out  8  running minute, binary.
- cur_second  out  8  running second, binary.
- min_pulse  out  1  one cycle; second wrapped SECOND-1 -> 0.
- hour_pulse  out  1  one cycle; minute wrapped MINUTE-1 -> 0.
- day_pulse  out  1  one cycle; hour wrapped HOUR-1 -> 0.
- load_done  out  1  one cycle; a commit was applied.
- load_err  out  1  one cycle; a commit contained at least one out-of-range field.

Behaviour:
- Reset (rst_n low, asynchronous): cur = RST_HOUR:00:00; all pulse outputs 0. Reset is honoured mid-count and mid-commit; any pending commit is lost.
- Commit condition: commit = leave & modify, sampled at posedge clk. leave with modify=0 does nothing, and the running time continues untouched.
- Commit action: on the next edge, each field loads its set_* value.
  - A field whose value is >= its modulus (set_hour >= HOUR, etc.) loads 0 instead.
  - load_done=1 that cycle; load_err=1 if any field was clamped.
  - A commit is one cycle, with no further handshake. The set-mode block clears modify after leave; this block does not depend on that.
- Priority in the same cycle: commit > tick. A tick coinciding with a commit is discarded; the loaded value is shown unincremented.
  - No carry pulses are generated by a commit, even if the loaded value equals a wrap boundary.
- Counting (tick=1, no commit), with latency 1 clk from tick to updated outputs:
  - second: if SECOND-1 -> 0 and min_pulse=1, else +1.
  - minute advances only when second wraps: if MINUTE-1 -> 0 and hour_pulse=1, else +1.
  - hour advances only when minute and second wrap together: if HOUR-1 -> 0 and day_pulse=1, else +1.
  - All pulses of one tick are asserted in the same cycle as the updated count.
- Counting continues while in set mode, so cur_* keeps running until a commit overwrites it.
- Widths:
  - Counters are 8 bit, unsigned binary.
  - Comparisons are against modulus-1, using 8-bit constants.
  - Parameters must be 1..255; a modulus of 1 holds the field at 0, and every carry-in produces that field's wrap pulse.
- Outputs are registered with no combinational path from inputs; pulses default 0 every cycle.
- Invariant: cur_* is always within range after reset.

Decomposition:
- Shared package clock_pkg holds:
  - default moduli HOUR_MOD=24, MIN_MOD=60, SEC_MOD=60;
  - RST_HOUR=8;
  - field width constant TIME_W=8.
- One natural sub-module, mod_cnt, instantiated three times (sec/min/hour) and chained via wrap outputs. It is parameterised by MOD and has:
  - inputs clk, rst_n, inc, load, load_val;
  - outputs q and wrap.
  - Its reset value is a parameter.
  - It performs range clamping on load.

Test Plan:
- Reset check: rst_n low -> cur=08:00:00 and all pulses 0. Release, then 3 ticks -> 08:00:03 with no pulses.
- Full rollover: commit 23:59:59 (leave=1, modify=1) -> load_done=1, load_err=0. Next tick -> 00:00:00, with min_pulse, hour_pulse and day_pulse all 1 for exactly one cycle.
- Minute carry only: from 10:14:59, tick -> 10:15:00 with min_pulse=1 and hour_pulse=0.
- Collision and no-op leave:
  - From 12:00:00, leave=1, modify=1, set 05:06:07, tick=1 the same cycle -> 05:06:07 (not :08), no carry pulses.
  - leave=1 with modify=0 -> time unchanged and load_done=0.
- Out-of-range commit: set 25:30:61 -> cur=00:30:00, load_done=1, load_err=1.
- Reset mid-count: assert rst_n low asynchronously between clk edges at 15:45:30 -> outputs go to 08:00:00 immediately, without waiting for a clock edge.
